// File: rtl/featuremap_pkg.sv
// rtl/featuremap_pkg.sv - shared types and constants for the feature-map pad writer
package featuremap_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    // IEEE-754 single-precision +0.0 is the all-zero word.
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/featuremap_pad_writer_if.sv
// rtl/featuremap_pad_writer_if.sv - upstream pixel stream and FIFO write bus of one channel
//
// Signals:
//   start            - frame start pulse (to writer)
//   data_in/valid_in - upstream pixel and its valid (to writer)
//   ready_in         - writer accepts data_in this cycle (from writer)
//   fifo_almost_full - FIFO has at most one free slot (to writer)
//   wrreq/data_out   - FIFO write strobe and data (from writer)
//   frame_done       - pulse with the last padded word (from writer)
interface featuremap_pad_writer_if #(
    parameter int DATA_WIDTH = featuremap_pkg::DATA_WIDTH_DEFAULT
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic                  fifo_almost_full;
    logic                  wrreq;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;

    // master: the pad writer itself
    modport master (
        input  start, data_in, valid_in, fifo_almost_full,
        output ready_in, wrreq, data_out, frame_done
    );

    // slave: upstream layer plus FIFO side
    modport slave (
        output start, data_in, valid_in, fifo_almost_full,
        input  ready_in, wrreq, data_out, frame_done
    );
endinterface

// File: rtl/pad_position_counter.sv
// rtl/pad_position_counter.sv - raster position counter over the padded (WIDTH+2)^2 frame
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - return to position (0,0)
//   advance   - step to the next raster position
//   row, col  - current padded position
//   border    - current position is in the zero ring
//   last      - current position is the bottom-right corner
module pad_position_counter #(
    parameter int WIDTH = 56
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        advance,
    output logic [$clog2(WIDTH+2)-1:0]  row,
    output logic [$clog2(WIDTH+2)-1:0]  col,
    output logic                        border,
    output logic                        last
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH + 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // Advancing past the final corner wraps to (0,0) so a counter left
    // after a completed frame is already positioned for the next one.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row    = row_q;
    assign col    = col_q;
    assign border = (row_q == '0) || (row_q == LAST_IDX) ||
                    (col_q == '0) || (col_q == LAST_IDX);
    assign last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/featuremap_pad_writer.sv
// rtl/featuremap_pad_writer.sv - writes a zero-padded raster of one channel into its FIFO
//
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - featuremap_pad_writer_if.master: start, pixel stream in,
//         FIFO almost-full in, registered FIFO write and frame_done out
module featuremap_pad_writer
    import featuremap_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int WIDTH      = 56
) (
    input  logic                     clk,
    input  logic                     rst,
    featuremap_pad_writer_if.master  bus
);
    localparam int CW = $clog2(WIDTH + 2);

    state_t                state_q, state_d;
    logic                  wrreq_q, wrreq_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ready;
    logic                  clear;
    logic                  advance;

    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  border;
    logic                  last;

    pad_position_counter #(.WIDTH(WIDTH)) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .row     (row),
        .col     (col),
        .border  (border),
        .last    (last)
    );

    // Almost-full gates everything because the write register adds one
    // word of latency; the FIFO flag supplies the matching slack slot.
    always_comb begin
        state_d = state_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        ready   = 1'b0;
        clear   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (!bus.fifo_almost_full) begin
                    if (border) begin
                        wrreq_d = 1'b1;
                        data_d  = DATA_WIDTH'(FP32_ZERO);
                        advance = 1'b1;
                    end else begin
                        ready = 1'b1;
                        if (bus.valid_in) begin
                            wrreq_d = 1'b1;
                            data_d  = bus.data_in;
                            advance = 1'b1;
                        end
                    end
                    if (advance && last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wrreq_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready_in   = ready;
    assign bus.wrreq      = wrreq_q;
    assign bus.data_out   = data_q;
    assign bus.frame_done = done_q;

    pos_in_range: assert property (@(posedge clk) disable iff (rst)
        (row <= CW'(WIDTH + 1)) && (col <= CW'(WIDTH + 1)));

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// tb/tb_featuremap_pad_writer.sv - scoreboard bench for featuremap_pad_writer
module tb_featuremap_pad_writer;
    localparam int W  = 4;
    localparam int DW = 32;
    localparam int P  = W + 2;
    localparam int NW = P * P;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    featuremap_pad_writer_if #(.DATA_WIDTH(DW)) bus ();

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] px_q[$];
    int          wr_cyc[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          words_seen = 0;
    int          done_seen  = 0;
    logic        prev_afull = 1'b0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] i2f(input int n);
        int e;
        int mant;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        mant = (n - (1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), 23'(mant)};
    endfunction

    // Reference: padded raster is zero on the ring, pixels in order inside.
    task automatic load_frame(input bit rnd);
        logic [31:0] pix[W*W];
        int k;
        exp_t e;
        for (int i = 0; i < W*W; i++) begin
            pix[i] = rnd ? $urandom : i2f(i + 1);
            px_q.push_back(pix[i]);
        end
        k = 0;
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < P; c++) begin
                if (r == 0 || r == P-1 || c == 0 || c == P-1) begin
                    e.data = 32'h0;
                end else begin
                    e.data = pix[k];
                    k++;
                end
                e.last = (r == P-1) && (c == P-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk_gap(input string name, input int idx, input int ref_cyc, input int gap);
        if (wr_cyc.size() > idx) begin
            chk(name, wr_cyc[idx] - ref_cyc, gap);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write %0d never seen, expected %0d cycles after %0d", name, idx, gap, ref_cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard whenever the DUT writes.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.fifo_almost_full) chk("ready_in_low_when_afull", bus.ready_in, 0);
            if (prev_afull) chk("no_wrreq_after_afull", bus.wrreq, 0);
            if (bus.wrreq) begin
                wr_cyc.push_back(cyc);
                words_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data %h, expected no write", bus.data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", bus.data_out, mon_e.data);
                    chk("frame_done", bus.frame_done, mon_e.last);
                end
                if (bus.frame_done) done_seen++;
            end else begin
                chk("frame_done_without_wrreq", bus.frame_done, 0);
            end
            prev_afull = bus.fifo_almost_full;
        end else begin
            prev_afull = 1'b0;
        end
    end

    // modes: 0 continuous, 1 toggling valid, 2 stall, 3 restart in RUN,
    //        4 reset after word 20, 5 back-to-back, 6 random
    task automatic run_frames(input int mode, input int nframes);
        int   target, base, start_cyc, b2b_cyc, stall_left, t;
        bit   hs, toggle, stalled, restarted, aborted;
        target     = done_seen + nframes;
        base       = words_seen;
        stall_left = 0;
        toggle     = 0;
        stalled    = 0;
        restarted  = 0;
        aborted    = 0;
        b2b_cyc    = 0;
        for (int f = 0; f < nframes; f++) load_frame(mode == 6);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        start_cyc = cyc;
        bus.valid_in = 1'b1;
        bus.data_in  = px_q[0];
        bus.fifo_almost_full = 1'b0;
        t = 0;
        while (done_seen < target && t < 2000 && !aborted) begin
            @(negedge clk);
            hs = bus.valid_in & bus.ready_in;
            @(posedge clk);
            #1;
            t++;
            if (hs) void'(px_q.pop_front());
            bus.start = 1'b0;
            if (mode == 3 && !restarted && words_seen - base >= 10) begin
                bus.start = 1'b1;
                restarted = 1;
            end
            if (mode == 5 && bus.frame_done && done_seen == target - nframes) begin
                bus.start = 1'b1;
                b2b_cyc = cyc;
            end
            if (mode == 4 && words_seen - base >= 20) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_async_wrreq", bus.wrreq, 0);
                chk("rst_async_data_out", bus.data_out, 0);
                chk("rst_async_frame_done", bus.frame_done, 0);
                chk("rst_async_ready_in", bus.ready_in, 0);
                exp_q.delete();
                px_q.delete();
                bus.valid_in = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                chk("rst_no_frame_done", done_seen, target - nframes);
                aborted = 1;
            end else begin
                if (mode == 2 && !stalled && words_seen - base >= 14) begin
                    stall_left = 10;
                    stalled = 1;
                end
                bus.fifo_almost_full = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                if (mode == 6) bus.fifo_almost_full = ($urandom_range(0, 4) == 0);
                toggle = ~toggle;
                case (mode)
                    1:       bus.valid_in = toggle;
                    6:       bus.valid_in = ($urandom_range(0, 2) != 0);
                    default: bus.valid_in = 1'b1;
                endcase
                if (px_q.size() == 0) bus.valid_in = 1'b0;
                bus.data_in = (px_q.size() != 0) ? px_q[0] : 32'h0;
            end
        end
        bus.start = 1'b0;
        bus.valid_in = 1'b0;
        bus.fifo_almost_full = 1'b0;
        if (!aborted) begin
            if (done_seen < target) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_timeout: mode %0d saw %0d frame_done, expected %0d", mode, done_seen, target);
            end
            repeat (6) @(posedge clk);
            #1;
            chk("frame_word_count", words_seen - base, NW * nframes);
            chk("frame_done_count", done_seen, target);
            chk("scoreboard_empty", exp_q.size(), 0);
            if (mode == 0 || mode == 5) begin
                chk_gap("first_write_latency", base, start_cyc, 2);
                chk_gap("back_to_back_writes", base + NW - 1, wr_cyc.size() > base ? wr_cyc[base] : 0, NW - 1);
            end
            if (mode == 5) chk_gap("b2b_second_frame_latency", base + NW, b2b_cyc, 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in = 32'h0;
        bus.fifo_almost_full = 1'b0;
        #1;
        chk("reset_wrreq", bus.wrreq, 0);
        chk("reset_data_out", bus.data_out, 0);
        chk("reset_frame_done", bus.frame_done, 0);
        chk("reset_ready_in", bus.ready_in, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus.valid_in = 1'b1;
        @(negedge clk);
        chk("idle_ready_in", bus.ready_in, 0);
        bus.valid_in = 1'b0;

        run_frames(0, 1);
        run_frames(1, 1);
        run_frames(2, 1);
        run_frames(3, 1);
        run_frames(4, 1);
        run_frames(0, 1);
        run_frames(5, 2);
        for (int i = 0; i < 3; i++) run_frames(6, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/featuremap_pad_writer.md
# featuremap_pad_writer

Producer end of the per-channel feature-map FIFO feeding the conv2D filter banks. Accepts a raster stream of WIDTH×WIDTH FP32 pixels from the previous layer and writes a zero-padded (WIDTH+2)×(WIDTH+2) raster into one channel FIFO. This matches the padded line width the downstream conv2D line buffers consume. One instance per channel; all instances of a layer share `start`.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: word width (IEEE-754 single).
- `WIDTH`, default 56: unpadded feature-map side length; padded side is WIDTH+2.

Ports:
- `clk` — in, 1: single clock; all logic on the rising edge.
- `rst` — in, 1: reset, asynchronous and active-high.
- `start` — in, 1: one-cycle pulse that begins a frame. Honoured only in IDLE.
- `data_in` — in, DATA_WIDTH: input pixel, raster order.
- `valid_in` — in, 1: `data_in` is valid this cycle.
- `ready_in` — out, 1: block accepts `data_in` this cycle. Combinational.
- `fifo_almost_full` — in, 1: FIFO holds ≥ depth−1 words; no new write may be issued.
- `wrreq` — out, 1: FIFO write strobe. Registered.
- `data_out` — out, DATA_WIDTH: FIFO write data. Registered.
- `frame_done` — out, 1: one-cycle pulse when the last padded word is written. Registered.

## Operation

- FSM states:
  - IDLE:
    - `start` → RUN; `row`=0, `col`=0.
  - RUN: walks positions (`row`,`col`), each 0..WIDTH+1, in raster order.
    - `border` = (`row`==0) | (`row`==WIDTH+1) | (`col`==0) | (`col`==WIDTH+1).
    - Border position, `fifo_almost_full`=0: write FP32 +0.0 (all-zero word), advance. `data_in` is not consumed.
    - Interior position:
      - `ready_in` = !`fifo_almost_full`.
      - `valid_in & ready_in`: write `data_in`, advance.
      - Otherwise: hold, no write.
    - `fifo_almost_full`=1: hold, no write, `ready_in`=0.
    - Advance rule: `col`++. On `col`==WIDTH+1, `col`→0 and `row`++.
    - On final position (WIDTH+1, WIDTH+1) written: → IDLE and pulse `frame_done`.
- `ready_in`=0 in IDLE and on border positions.
- Per frame: exactly (WIDTH+2)² writes and exactly WIDTH² input handshakes. Default parameters give 3364 writes and 3136 handshakes.
- `start` during RUN is ignored; it is not queued.
- `valid_in` with `ready_in`=0: word not taken; upstream must hold it.
- Counters are ⌈log2(WIDTH+2)⌉ bits and never exceed WIDTH+1.

## Timing

- Reset values: state IDLE, `row`/`col` 0, `wrreq` 0, `data_out` 0, `frame_done` 0.
  - `ready_in` is 0 during and after reset until RUN at an interior position.
- Write decision made in cycle t; `wrreq`/`data_out` visible in cycle t+1, asserted for exactly one cycle per word.
- `frame_done` asserts in the same cycle as `wrreq` for the final word.
- Latency:
  - `start` at cycle t: first `wrreq` (top-left zero) at t+2, if not almost-full.
  - Minimum frame: (WIDTH+2)² cycles of continuous writes when never stalled.
- Throughput: one word per cycle; border words are written back-to-back with no input dependency.
- `fifo_almost_full` is sampled at decision time. The one-deep write register is why the FIFO flag must have one-slot slack.
- Reset mid-frame: immediate abort, return to IDLE, no `frame_done`. The partial FIFO contents are the consumer's problem; the FIFO is reset by the same `rst`.
- `frame_done` and a new `start` in the same cycle: `start` is honoured, because state is already IDLE at that decision edge.

## Structure

- Shared package `featuremap_pkg`:
  - state typedef (IDLE, RUN);
  - `FP32_ZERO` constant;
  - `DATA_WIDTH` default.
- Sub-module `pad_position_counter`:
  - parameter WIDTH;
  - inputs `clear`, `advance`;
  - outputs `row`, `col`, `border`, `last`.
  - Owns wrap logic.
- Top holds the FSM, ready/write decision and output registers.

## Test plan

- WIDTH=4, `start`, `valid_in` held high with pixels 1.0..16.0, FIFO never full → 36 consecutive writes.
  - Rows 0 and 5 all zero; each interior row is 0, four pixels, 0.
  - `frame_done` on write 36.
- Same frame with `valid_in` toggling every other cycle → identical 36-word sequence.
  - Border words are not delayed by missing input; no pixel is dropped or duplicated.
- `fifo_almost_full` forced high for 10 cycles mid-row 2 → no `wrreq` and `ready_in`=0 during the stall; sequence resumes intact; total 36 words.
- `start` pulsed again during RUN → ignored; exactly one frame of 36 words.
- `rst` asserted after word 20 → outputs 0 asynchronously, no `frame_done`.
  - Next `start` produces a full fresh 36-word frame from position (0,0).
- Back-to-back: `start` in the same cycle as `frame_done` → second frame's first `wrreq` two cycles later; two `frame_done` pulses in total.
